alu_exec_unit: RTL

Execute-stage ALU driven directly by the ALU controller's `ALUCtrl` and `bonus_control` outputs. Performs single-cycle AND/OR/ADD/SUB/compare operations and a 32-iteration shift-add multiply. Provides a valid/ready handshake so the pipeline can stall while a multiply is in flight. All results are registered.

---
 rtl/alu_exec_pkg.sv | 18 +
 rtl/alu_exec_if.sv | 24 ++
 rtl/shift_add_mul.sv | 47 ++++
 rtl/alu_exec_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared opcode constants and state encoding for the execute-stage ALU.
package alu_exec_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_CMP = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  localparam logic [2:0] CMP_LT = 3'b000;
  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_NE = 3'b100;
  localparam logic [2:0] CMP_GE = 3'b101;

  typedef enum logic {IDLE, MUL} state_t;

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between the pipeline and the execute-stage ALU.
interface alu_exec_if #(parameter int WIDTH = 32);

  logic             valid_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ALUCtrl_i;
  logic [2:0]       bonus_ctrl_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;

  modport master (
    output valid_i, src1_i, src2_i, ALUCtrl_i, bonus_ctrl_i,
    input  ready_o, valid_o, result_o, zero_o
  );

  modport slave (
    input  valid_i, src1_i, src2_i, ALUCtrl_i, bonus_ctrl_i,
    output ready_o, valid_o, result_o, zero_o
  );

endinterface

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier, one multiplier bit per step, WIDTH steps total.
module shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  // The final iteration's add is folded into the product so the result lands on the same edge.
  assign done     = step && (cnt_reg == CW'(WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (start) begin
      mcand_reg  <= src_a;
      mplier_reg <= src_b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (step) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare plus a stalling multi-cycle multiply.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_exec_if.slave  bus
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic             zero_reg;
  logic             valid_reg;
  logic             result_load;
  logic             mul_start;
  logic             mul_step;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_result;
  logic             cmp_bit;
  logic             lt;
  logic             accept;

  assign bus.ready_o  = (state_reg == IDLE);
  assign bus.valid_o  = valid_reg;
  assign bus.result_o = result_reg;
  assign bus.zero_o   = zero_reg;
  assign accept       = bus.valid_i && bus.ready_o;
  assign mul_step     = (state_reg == MUL);
  assign lt           = $signed(bus.src1_i) < $signed(bus.src2_i);

  always_comb begin
    cmp_bit = lt;
    case (bus.bonus_ctrl_i)
      CMP_GT:  cmp_bit = $signed(bus.src1_i) > $signed(bus.src2_i);
      CMP_NE:  cmp_bit = bus.src1_i != bus.src2_i;
      CMP_GE:  cmp_bit = !lt;
      default: cmp_bit = lt;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (bus.ALUCtrl_i)
      ALU_AND: alu_result = bus.src1_i & bus.src2_i;
      ALU_OR:  alu_result = bus.src1_i | bus.src2_i;
      ALU_ADD: alu_result = bus.src1_i + bus.src2_i;
      ALU_SUB: alu_result = bus.src1_i - bus.src2_i;
      ALU_CMP: alu_result = WIDTH'(cmp_bit);
      default: alu_result = '0;
    endcase
  end

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (mul_start),
    .step    (mul_step),
    .src_a   (bus.src1_i),
    .src_b   (bus.src2_i),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_next  = state_reg;
    mul_start   = 1'b0;
    result_load = 1'b0;
    result_next = alu_result;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bus.ALUCtrl_i == ALU_MUL) begin
            mul_start  = 1'b1;
            state_next = MUL;
          end else begin
            result_load = 1'b1;
          end
        end
      end
      MUL: begin
        // Requests are ignored here; ready_o is low so nothing is accepted.
        if (mul_done) begin
          result_load = 1'b1;
          result_next = mul_product;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= result_load;
      if (result_load) begin
        result_reg <= result_next;
        zero_reg   <= (result_next == '0);
      end
    end
  end

endmodule
